// File: rtl/config_loader.sv
// config_loader: configuration master for the tile array.
// Takes (address, data) write records from a valid/ready word stream.
// Each write is presented on config_addr/config_data for HOLD_CYCLES cycles.
// Between writes the bus is parked on IDLE_ADDR, which no tile decodes.
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN. When it is defined, a
// trailer word must equal the XOR of the header, address and data words.
module config_loader #(
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [15:0] MAGIC       = 16'hC0F1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] write_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_ADDR,
        S_DATA,
        S_DRIVE,
        S_FINISH,
        S_ERR
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pend_q, pend_d;
    logic [15:0] remaining_q, remaining_d;
    logic [3:0]  hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        xfer;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    // Next-state, handshake and bus update logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pend_d      = pend_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;
        wcnt_d      = wcnt_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        in_ready    = 1'b0;
        xfer        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    wcnt_d  = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    remaining_d = in_data[15:0];
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ in_data;
`endif
                    if (in_data[31:16] != MAGIC)  state_d = S_ERR;
                    else if (in_data[15:0] == '0) state_d = S_FINISH;
                    else                          state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    pend_d  = in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = (in_data == IDLE_ADDR) ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    addr_d      = pend_q;
                    data_d      = in_data;
                    hold_d      = HOLD_LOAD;
                    wcnt_d      = wcnt_q + 16'd1;
                    remaining_d = remaining_q - 16'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ in_data;
`endif
                    state_d     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (hold_q == '0) begin
                    addr_d  = IDLE_ADDR;
                    data_d  = '0;
                    state_d = (remaining_q != '0) ? S_ADDR : S_FINISH;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_FINISH: begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                in_ready = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    if (in_data == csum_q) done_d = 1'b1;
                    else                   error_d = 1'b1;
                    state_d = S_IDLE;
                end
`else
                done_d  = 1'b1;
                state_d = S_IDLE;
`endif
            end
            S_ERR: begin
                error_d = 1'b1;
                addr_d  = IDLE_ADDR;
                data_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                addr_d  = IDLE_ADDR;
                data_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset parks the bus immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= IDLE_ADDR;
            data_q      <= '0;
            pend_q      <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wcnt_q      <= '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wcnt_q      <= wcnt_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign config_addr = addr_q;
    assign config_data = data_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign write_count = wcnt_q;

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader: two instances (HOLD_CYCLES 1 and 3).
// A bus monitor checks every presented write against a scoreboard queue.
module tb_config_loader;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        start_s    [2];
    logic        in_valid_s [2];
    logic [31:0] in_data_s  [2];
    logic        ready_s    [2];
    logic [31:0] addr_s     [2];
    logic [31:0] data_s     [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic        error_s    [2];
    logic [15:0] wc_s       [2];

    config_loader #(.HOLD_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .in_data(in_data_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(ready_s[0]), .config_addr(addr_s[0]),
        .config_data(data_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .error(error_s[0]), .write_count(wc_s[0])
    );

    config_loader #(.HOLD_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .in_data(in_data_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(ready_s[1]), .config_addr(addr_s[1]),
        .config_data(data_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .error(error_s[1]), .write_count(wc_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        k;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    bit          mon_en = 1'b1;
    int          run_len [2] = '{0, 0};
    logic [31:0] cur_a   [2];
    logic [31:0] cur_d   [2];

    // Bus monitor: measures each write's presentation length and compares it
    always @(negedge clk) begin
        if (mon_en && reset) begin
            for (int k = 0; k < 2; k++) begin
                if (addr_s[k] != IDLE) begin
                    if (run_len[k] == 0) begin
                        cur_a[k] = addr_s[k];
                        cur_d[k] = data_s[k];
                    end else begin
                        chk("bus_stable_addr", addr_s[k], cur_a[k]);
                        chk("bus_stable_data", data_s[k], cur_d[k]);
                    end
                    run_len[k]++;
                end else if (run_len[k] != 0) begin
                    chk("parked_data", data_s[k], 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", cur_a[k], IDLE);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("write_dut", 32'(k), 32'(e.k));
                        chk("write_addr", cur_a[k], e.a);
                        chk("write_data", cur_d[k], e.d);
                        chk("write_hold", 32'(run_len[k]), (k == 0) ? 32'd1 : 32'd3);
                    end
                    run_len[k] = 0;
                end
            end
        end
    end

    logic [31:0] rec_a [4];
    logic [31:0] rec_d [4];

    task automatic pulse_start(input int k);
        in_valid_s[k] = 1'b0;
        @(negedge clk);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    // Offer one word until it is accepted; in_valid stays high afterwards
    task automatic send(input int k, input logic [31:0] w, input bit rnd);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            in_data_s[k]  = w;
            in_valid_s[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid_s[k] && ready_s[k]) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("send_timeout", w, 32'hDEAD_DEAD);
    endtask

    task automatic wait_idle(input int k);
        in_valid_s[k] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy_s[k]) return;
        end
        chk("idle_timeout", 32'(busy_s[k]), 32'd0);
    endtask

    // Full load of n records from rec_a/rec_d; mid>=0 pulses start before record mid
    task automatic run_load(input int k, input int n, input bit rnd, input int mid, input bit flip);
        logic [31:0] hdr;
        logic [31:0] cs;
        exp_t e;
        hdr = {16'hC0F1, 16'(n)};
        cs  = hdr;
        pulse_start(k);
        send(k, hdr, rnd);
        for (int i = 0; i < n; i++) begin
            if (i == mid) pulse_start(k);
            e.k = 1'(k);
            e.a = rec_a[i];
            e.d = rec_d[i];
            exp_q.push_back(e);
            send(k, rec_a[i], rnd);
            send(k, rec_d[i], rnd);
            cs = cs ^ rec_a[i] ^ rec_d[i];
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send(k, cs ^ {31'd0, flip}, rnd);
`else
        if (flip) cs = '0;
`endif
        wait_idle(k);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k]    = 1'b0;
            in_valid_s[k] = 1'b0;
            in_data_s[k]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_addr",  addr_s[k], IDLE);
            chk("rst_data",  data_s[k], 32'd0);
            chk("rst_ready", 32'(ready_s[k]), 32'd0);
            chk("rst_busy",  32'(busy_s[k]), 32'd0);
            chk("rst_done",  32'(done_s[k]), 32'd0);
            chk("rst_error", 32'(error_s[k]), 32'd0);
            chk("rst_wc",    32'(wc_s[k]), 32'd0);
        end

        // Single write, HOLD_CYCLES=1
        rec_a[0] = 32'h0007_0003; rec_d[0] = 32'h0000_0005;
        run_load(0, 1, 1'b0, -1, 1'b0);
        chk("single_done", 32'(done_s[0]), 32'd1);
        chk("single_err",  32'(error_s[0]), 32'd0);
        chk("single_wc",   32'(wc_s[0]), 32'd1);

        // Three records, HOLD_CYCLES=3, random in_valid
        rec_a[0] = 32'h0001_0010; rec_d[0] = 32'hA5A5_0001;
        rec_a[1] = 32'h0002_0011; rec_d[1] = 32'h1234_5678;
        rec_a[2] = 32'h0003_0012; rec_d[2] = 32'hFFFF_0000;
        run_load(1, 3, 1'b1, -1, 1'b0);
        chk("three_done", 32'(done_s[1]), 32'd1);
        chk("three_wc",   32'(wc_s[1]), 32'd3);

        // Bad header tag
        pulse_start(0);
        send(0, 32'hBEEF_0002, 1'b0);
        in_valid_s[0] = 1'b0;
        chk("badhdr_err_early", 32'(error_s[0]), 32'd0);
        chk("badhdr_busy",      32'(busy_s[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("badhdr_err",  32'(error_s[0]), 32'd1);
        chk("badhdr_done", 32'(done_s[0]), 32'd0);
        chk("badhdr_idle", 32'(busy_s[0]), 32'd0);
        chk("badhdr_bus",  addr_s[0], IDLE);

        // Recovery load clears error
        rec_a[0] = 32'h0005_0001; rec_d[0] = 32'h0BAD_F00D;
        run_load(0, 1, 1'b0, -1, 1'b0);
        chk("recover_err",  32'(error_s[0]), 32'd0);
        chk("recover_done", 32'(done_s[0]), 32'd1);

        // Record address equal to the parking address
        pulse_start(0);
        send(0, 32'hC0F1_0001, 1'b0);
        send(0, IDLE, 1'b0);
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("idleaddr_err",  32'(error_s[0]), 32'd1);
        chk("idleaddr_done", 32'(done_s[0]), 32'd0);
        chk("idleaddr_wc",   32'(wc_s[0]), 32'd0);

        // start pulsed mid-load is ignored
        rec_a[0] = 32'h0009_0001; rec_d[0] = 32'h0000_0011;
        rec_a[1] = 32'h0009_0002; rec_d[1] = 32'h0000_0022;
        run_load(0, 2, 1'b0, 1, 1'b0);
        chk("midstart_done", 32'(done_s[0]), 32'd1);
        chk("midstart_wc",   32'(wc_s[0]), 32'd2);

        // Empty load (N=0)
        run_load(1, 0, 1'b0, -1, 1'b0);
        chk("empty_done", 32'(done_s[1]), 32'd1);
        chk("empty_wc",   32'(wc_s[1]), 32'd0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
        rec_a[0] = 32'h0006_0002; rec_d[0] = 32'h0000_0004;
        run_load(0, 1, 1'b0, -1, 1'b0);
        chk("csum_ok_done", 32'(done_s[0]), 32'd1);
        chk("csum_ok_err",  32'(error_s[0]), 32'd0);
        run_load(0, 1, 1'b0, -1, 1'b1);
        chk("csum_bad_err",  32'(error_s[0]), 32'd1);
        chk("csum_bad_done", 32'(done_s[0]), 32'd0);
        chk("csum_bad_wc",   32'(wc_s[0]), 32'd1);
`endif

        // Reset during a held write parks the bus without a clock edge
        mon_en = 1'b0;
        rec_a[0] = 32'h0004_0004; rec_d[0] = 32'h4444_4444;
        pulse_start(1);
        send(1, 32'hC0F1_0001, 1'b0);
        send(1, rec_a[0], 1'b0);
        send(1, rec_d[0], 1'b0);
        in_valid_s[1] = 1'b0;
        chk("midrst_driven", addr_s[1], rec_a[0]);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_addr", addr_s[1], IDLE);
        chk("midrst_data", data_s[1], 32'd0);
        chk("midrst_busy", 32'(busy_s[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Configuration master for the tile array.
- Consumes a word stream of (address, data) write records over a valid/ready handshake and drives the shared config_addr/config_data bus that every tile decodes.
- A tile fires its config enable whenever config_addr[15:0] matches tile_id and config_addr[31:16] matches a sub-block ID. The bus therefore has no strobe: the loader presents each write for a fixed number of cycles, then parks the bus on an address no tile decodes.

Parameters:
- IDLE_ADDR, 32'hFFFF_FFFF: bus parking address; no tile or sub-block may use it.
- HOLD_CYCLES, 1: cycles each write is presented on the bus; legal range 1..15.
- MAGIC, 16'hC0F1: required header tag.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse that begins a load; sampled only when the loader is not busy.
- in_data  input  32  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- config_addr  output  32  configuration address bus to all tiles.
- config_data  output  32  configuration data bus to all tiles.
- busy  output  1  load in progress.
- done  output  1  last load completed cleanly; level.
- error  output  1  last load aborted or failed check; level.
- write_count  output  16  writes issued in the current or last load.

Behaviour:
- Reset (async, reset=0):
  - FSM goes to IDLE.
  - config_addr=IDLE_ADDR, config_data=0.
  - in_ready=0, busy=0, done=0, error=0, write_count=0.
- Transfers: a word transfers on any rising edge where in_valid and in_ready are both 1. No transfer happens otherwise. in_data is ignored when in_ready=0.
- IDLE:
  - in_ready=0.
  - On start=1: clear done, error and write_count; go to HEADER.
- HEADER:
  - in_ready=1.
  - The accepted word must have [31:16]==MAGIC; [15:0] is N, the record count, loaded into a remaining counter.
  - Tag mismatch -> ERR.
  - N==0 -> FINISH.
  - Otherwise -> ADDR.
- ADDR:
  - in_ready=1.
  - The accepted word is latched as the pending address.
  - If it equals IDLE_ADDR -> ERR; nothing is driven.
  - Otherwise -> DATA.
- DATA:
  - in_ready=1.
  - On acceptance, config_addr and config_data update on that same edge to the pending pair.
  - A hold counter loads HOLD_CYCLES-1; write_count increments; remaining decrements.
  - Next state is DRIVE.
- DRIVE:
  - in_ready=0; the bus holds the pair for exactly HOLD_CYCLES cycles total.
  - When the hold counter is 0: on the next edge the bus returns to IDLE_ADDR/0.
  - Next state is ADDR if remaining!=0, else FINISH.
  - At least one idle-bus cycle separates consecutive writes, so back-to-back records take HOLD_CYCLES+2 cycles each minimum.
- FINISH: set done=1 and go to IDLE. With the checksum feature enabled, FINISH first accepts the trailer (see Optional Feature).
- ERR:
  - error=1 and the bus is parked.
  - Go to IDLE on the next edge.
  - Remaining stream words are not consumed; upstream must flush.
- Status outputs:
  - busy=1 in every state except IDLE.
  - done and error are mutually exclusive and hold until the next accepted start.
- start while busy: ignored, no effect.
- in_valid stalls in HEADER, ADDR or DATA: the FSM waits indefinitely and the bus stays parked.
- Reset asserted mid-write: the bus parks immediately (asynchronously). A partially written tile is not rolled back.
- write_count: wraps at 16 bits. This is unreachable with N≤65535.
- Bus outputs are registered; there are no combinational paths from in_data to config_addr or config_data.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running XOR covers the header, every address word and every data word.
  - After the last record, FINISH keeps in_ready=1 and accepts one trailer word.
  - Trailer == running XOR -> done=1; mismatch -> error=1.
  - Writes already issued are not undone.
- Undefined: no trailer word is consumed; FINISH sets done one cycle after the final DRIVE.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> config_addr=32'hFFFF_FFFF, config_data=0, in_ready=0, busy=0, done=0, error=0.
- Single write: start; stream 32'hC0F1_0001, 32'h0007_0003, 32'h0000_0005 with in_valid held 1; HOLD_CYCLES=1 -> config_addr=32'h0007_0003 and config_data=5 for exactly 1 cycle, then parked; done=1, write_count=1.
- Three records with HOLD_CYCLES=3 and in_valid toggled randomly -> each pair is held exactly 3 cycles, each separated by ≥1 parked cycle, in stream order; write_count=3.
- Bad header 32'hBEEF_0002 -> error=1 and done=0 one cycle after acceptance; the bus never leaves IDLE_ADDR; the next start with a valid stream succeeds and clears error.
- Record address 32'hFFFF_FFFF, and separately start pulsed mid-load -> the first gives error=1 with no bus activity; the second is ignored and the load completes normally.
- With CONFIG_LOADER_CHECKSUM_EN: header 32'hC0F1_0001, addr 32'h0006_0002, data 32'h0000_0004, trailer equal to the XOR of those three -> done=1; same stream with trailer bit 0 flipped -> error=1 after the write is issued.
